bcd_calc_core: RTL and testbench



---
 rtl/bcd_calc_core.sv | 275 +++++++++++++++++++++++++++
 tb/tb_bcd_calc_core.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bcd_calc_core.sv
// Keypad-driven BCD calculator core: shift-in entry of two DIGITS-wide BCD operands,
// then a digit-serial add/subtract producing a signed (DIGITS+1)-digit result.
module bcd_calc_core #(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      key_strobe,
    input  logic [3:0]                key_code,
    output logic [1:0]                st,
    output logic [4*(DIGITS+1)-1:0]   disp_bcd,
    output logic                      neg,
    output logic                      op_sub,
    output logic                      busy,
    output logic                      result_valid,
    output logic                      err
);
    localparam int W  = 4 * DIGITS;
    localparam int RW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(DIGITS);

    localparam logic [1:0] ENTER_A = 2'd0;
    localparam logic [1:0] ENTER_B = 2'd1;
    localparam logic [1:0] CALC    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_DIG  = 3'd1;
    localparam logic [2:0] K_OP   = 3'd2;
    localparam logic [2:0] K_EQ   = 3'd3;
    localparam logic [2:0] K_CLR  = 3'd4;
    localparam logic [2:0] K_BS   = 3'd5;

    logic [W-1:0]  a_r, b_r, x_r, y_r;
    logic [RW-1:0] r_r;
    logic [CW-1:0] cnt_a_r, cnt_b_r;
    logic [IW-1:0] idx_r;
    logic          carry_r, neg_r;

    logic [1:0]    st_nxt;
    logic [W-1:0]  a_nxt, b_nxt, x_nxt, y_nxt;
    logic [RW-1:0] r_nxt;
    logic [CW-1:0] cnt_a_nxt, cnt_b_nxt;
    logic [IW-1:0] idx_nxt;
    logic          carry_nxt, neg_nxt, op_nxt, err_s, rv_s;

    logic [2:0]    kc_s;
    logic [3:0]    xd_s, yd_s, dig_s;
    logic [4:0]    sum_s, rhs_s, diff_s;
    logic          c_s;

    // Classify the incoming key into the command groups the FSM reacts to.
    always_comb begin
        kc_s = K_NONE;
        if (!key_strobe) begin
            kc_s = K_NONE;
        end else begin
            case (key_code)
                4'd10, 4'd11: kc_s = K_OP;
                4'd12:        kc_s = K_EQ;
                4'd13:        kc_s = K_CLR;
                4'd14:        kc_s = K_BS;
                4'd15:        kc_s = K_NONE;
                default:      kc_s = K_DIG;
            endcase
        end
    end

    // One BCD digit of X +/- Y with incoming carry/borrow.
    always_comb begin
        xd_s   = x_r[{idx_r, 2'b00} +: 4];
        yd_s   = y_r[{idx_r, 2'b00} +: 4];
        sum_s  = {1'b0, xd_s} + {1'b0, yd_s} + {4'b0000, carry_r};
        rhs_s  = {1'b0, yd_s} + {4'b0000, carry_r};
        diff_s = 5'd0;
        dig_s  = 4'd0;
        c_s    = 1'b0;
        if (op_r_sub()) begin
            if ({1'b0, xd_s} < rhs_s) begin
                diff_s = {1'b0, xd_s} + 5'd10 - rhs_s;
                c_s    = 1'b1;
            end else begin
                diff_s = {1'b0, xd_s} - rhs_s;
                c_s    = 1'b0;
            end
            dig_s = diff_s[3:0];
        end else begin
            if (sum_s > 5'd9) begin
                diff_s = sum_s - 5'd10;
                c_s    = 1'b1;
            end else begin
                diff_s = sum_s;
                c_s    = 1'b0;
            end
            dig_s = diff_s[3:0];
        end
    end

    function automatic logic op_r_sub();
        return op_sub;
    endfunction

    // Next-state logic for entry, calculation and chaining.
    always_comb begin
        st_nxt    = st;
        a_nxt     = a_r;
        b_nxt     = b_r;
        x_nxt     = x_r;
        y_nxt     = y_r;
        r_nxt     = r_r;
        cnt_a_nxt = cnt_a_r;
        cnt_b_nxt = cnt_b_r;
        idx_nxt   = idx_r;
        carry_nxt = carry_r;
        neg_nxt   = neg_r;
        op_nxt    = op_sub;
        err_s     = 1'b0;
        rv_s      = 1'b0;
        case (st)
            CALC: begin
                r_nxt[{idx_r, 2'b00} +: 4] = dig_s;
                carry_nxt = c_s;
                if (idx_r == IW'(DIGITS - 1)) begin
                    r_nxt[W +: 4] = op_sub ? 4'd0 : {3'b000, c_s};
                    st_nxt = DONE;
                    rv_s   = 1'b1;
                end else begin
                    idx_nxt = idx_r + IW'(1);
                end
            end
            default: begin
                case (kc_s)
                    K_CLR: begin
                        a_nxt     = {W{1'b0}};
                        b_nxt     = {W{1'b0}};
                        r_nxt     = {RW{1'b0}};
                        cnt_a_nxt = {CW{1'b0}};
                        cnt_b_nxt = {CW{1'b0}};
                        neg_nxt   = 1'b0;
                        op_nxt    = 1'b0;
                        st_nxt    = ENTER_A;
                    end
                    K_DIG: begin
                        if (st == ENTER_A) begin
                            if (cnt_a_r < CW'(DIGITS)) begin
                                a_nxt     = {a_r[W-5:0], key_code};
                                cnt_a_nxt = cnt_a_r + CW'(1);
                            end else begin
                                err_s = 1'b1;
                            end
                        end else if (st == ENTER_B) begin
                            if (cnt_b_r < CW'(DIGITS)) begin
                                b_nxt     = {b_r[W-5:0], key_code};
                                cnt_b_nxt = cnt_b_r + CW'(1);
                            end else begin
                                err_s = 1'b1;
                            end
                        end else begin
                            a_nxt     = {{(W-4){1'b0}}, key_code};
                            cnt_a_nxt = CW'(1);
                            b_nxt     = {W{1'b0}};
                            neg_nxt   = 1'b0;
                            st_nxt    = ENTER_A;
                        end
                    end
                    K_BS: begin
                        if (st == ENTER_A) begin
                            a_nxt     = {4'h0, a_r[W-1:4]};
                            cnt_a_nxt = (cnt_a_r == {CW{1'b0}}) ? cnt_a_r : cnt_a_r - CW'(1);
                        end else if (st == ENTER_B) begin
                            b_nxt     = {4'h0, b_r[W-1:4]};
                            cnt_b_nxt = (cnt_b_r == {CW{1'b0}}) ? cnt_b_r : cnt_b_r - CW'(1);
                        end else begin
                            a_nxt = a_r;
                        end
                    end
                    K_OP: begin
                        if (st == ENTER_A) begin
                            op_nxt    = key_code[0];
                            b_nxt     = {W{1'b0}};
                            cnt_b_nxt = {CW{1'b0}};
                            st_nxt    = ENTER_B;
                        end else if (st == ENTER_B) begin
                            op_nxt = key_code[0];
                        end else if ((r_r[W +: 4] == 4'd0) && !neg_r) begin
                            // Chain: the previous result becomes the new first operand.
                            a_nxt     = r_r[W-1:0];
                            cnt_a_nxt = CW'(DIGITS);
                            op_nxt    = key_code[0];
                            b_nxt     = {W{1'b0}};
                            cnt_b_nxt = {CW{1'b0}};
                            st_nxt    = ENTER_B;
                        end else begin
                            err_s = 1'b1;
                        end
                    end
                    K_EQ: begin
                        if (st == ENTER_B) begin
                            // Subtract always runs larger minus smaller; the sign is kept apart.
                            if (op_sub && (a_r < b_r)) begin
                                x_nxt   = b_r;
                                y_nxt   = a_r;
                                neg_nxt = 1'b1;
                            end else begin
                                x_nxt   = a_r;
                                y_nxt   = b_r;
                                neg_nxt = 1'b0;
                            end
                            idx_nxt   = {IW{1'b0}};
                            carry_nxt = 1'b0;
                            r_nxt     = {RW{1'b0}};
                            st_nxt    = CALC;
                        end else begin
                            st_nxt = st;
                        end
                    end
                    default: st_nxt = st;
                endcase
            end
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            x_r     <= {W{1'b0}};
            y_r     <= {W{1'b0}};
            r_r     <= {RW{1'b0}};
            cnt_a_r <= {CW{1'b0}};
            cnt_b_r <= {CW{1'b0}};
            idx_r   <= {IW{1'b0}};
            carry_r <= 1'b0;
            neg_r   <= 1'b0;
            op_sub  <= 1'b0;
            st      <= ENTER_A;
        end else begin
            a_r     <= a_nxt;
            b_r     <= b_nxt;
            x_r     <= x_nxt;
            y_r     <= y_nxt;
            r_r     <= r_nxt;
            cnt_a_r <= cnt_a_nxt;
            cnt_b_r <= cnt_b_nxt;
            idx_r   <= idx_nxt;
            carry_r <= carry_nxt;
            neg_r   <= neg_nxt;
            op_sub  <= op_nxt;
            st      <= st_nxt;
        end
    end

    // Registered display and status outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_bcd     <= {RW{1'b0}};
            neg          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (st_nxt)
                ENTER_A: disp_bcd <= {4'h0, a_nxt};
                DONE:    disp_bcd <= r_nxt;
                default: disp_bcd <= {4'h0, b_nxt};
            endcase
            neg          <= (st_nxt == DONE) ? neg_nxt : 1'b0;
            busy         <= (st_nxt == CALC);
            result_valid <= rv_s;
            err          <= err_s;
        end
    end
endmodule

// File: tb/tb_bcd_calc_core.sv
// Directed self-checking bench for bcd_calc_core with DIGITS=4.
module tb_bcd_calc_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_strobe = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [1:0]  st;
    logic [19:0] disp_bcd;
    logic        neg, op_sub, busy, result_valid, err;
    int          checks = 0;
    int          errors = 0;

    bcd_calc_core #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .key_strobe(key_strobe), .key_code(key_code),
        .st(st), .disp_bcd(disp_bcd), .neg(neg), .op_sub(op_sub),
        .busy(busy), .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_strobe = 1'b1;
        key_code   = c;
        @(posedge clk);
        #1;
        key_strobe = 1'b0;
        key_code   = 4'd15;
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+":     press(4'd10);
                "-":     press(4'd11);
                "C":     press(4'd13);
                "B":     press(4'd14);
                default: press(4'(s[i] - "0"));
            endcase
        end
    endtask

    // Press '=' and verify the CALC window and result_valid latency.
    task automatic equals(input string tag);
        int n, busy_cnt;
        press(4'd12);
        check({tag, "_st_calc"}, {30'd0, st}, 32'd2);
        busy_cnt = busy ? 1 : 0;
        n = 0;
        while (!result_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, n, 32'd4);
        check({tag, "_busy_cycles"}, busy_cnt, 32'd4);
        check({tag, "_st_done"}, {30'd0, st}, 32'd3);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("rst_st", {30'd0, st}, 32'd0);
        check("rst_disp", {12'd0, disp_bcd}, 32'd0);
        check("rst_flags", {27'd0, neg, op_sub, busy, result_valid, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        keys("1234");
        check("t1_a", {12'd0, disp_bcd}, 32'h01234);
        keys("+");
        check("t1_plus_st", {30'd0, st}, 32'd1);
        check("t1_plus_disp", {12'd0, disp_bcd}, 32'h0);
        check("t1_op", {31'd0, op_sub}, 32'd0);
        keys("5678");
        check("t1_b", {12'd0, disp_bcd}, 32'h05678);
        equals("t1");
        check("t1_res", {12'd0, disp_bcd}, 32'h06912);
        check("t1_neg", {31'd0, neg}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_rv_pulse", {31'd0, result_valid}, 32'd0);

        keys("12-");
        check("t2_op", {31'd0, op_sub}, 32'd1);
        keys("345");
        equals("t2");
        check("t2_res", {12'd0, disp_bcd}, 32'h00333);
        check("t2_neg", {31'd0, neg}, 32'd1);

        keys("500-1");
        equals("t3");
        check("t3_res", {12'd0, disp_bcd}, 32'h00499);
        check("t3_neg", {31'd0, neg}, 32'd0);

        keys("9999+9999");
        equals("t4");
        check("t4_res", {12'd0, disp_bcd}, 32'h19998);
        keys("+");
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_st", {30'd0, st}, 32'd3);
        @(posedge clk);
        #1;
        check("t4_err_pulse", {31'd0, err}, 32'd0);

        keys("1234");
        check("t5_noerr", {31'd0, err}, 32'd0);
        keys("5");
        check("t5_err", {31'd0, err}, 32'd1);
        check("t5_a", {12'd0, disp_bcd}, 32'h01234);
        keys("BB");
        check("t5_bs", {12'd0, disp_bcd}, 32'h00012);
        keys("C");
        check("t5_clr", {12'd0, disp_bcd}, 32'h0);
        check("t5_clr_st", {30'd0, st}, 32'd0);

        keys("5+3");
        equals("t6a");
        check("t6_res1", {12'd0, disp_bcd}, 32'h00008);
        keys("+");
        check("t6_chain_st", {30'd0, st}, 32'd1);
        keys("2");
        equals("t6b");
        check("t6_res2", {12'd0, disp_bcd}, 32'h00010);
        keys("7");
        check("t6_dig_st", {30'd0, st}, 32'd0);
        check("t6_dig_disp", {12'd0, disp_bcd}, 32'h00007);

        keys("C1+2");
        press(4'd12);
        @(posedge clk);
        #1;
        check("t7_in_calc", {30'd0, st}, 32'd2);
        rst = 1'b1;
        #1;
        check("t7_rst_st", {30'd0, st}, 32'd0);
        check("t7_rst_disp", {12'd0, disp_bcd}, 32'h0);
        check("t7_rst_flags", {27'd0, neg, op_sub, busy, result_valid, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        keys("3+4");
        equals("t7");
        check("t7_res", {12'd0, disp_bcd}, 32'h00007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
